muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameters: NB_DATA, 32, operand/HI/LO width; NB_FUNCT, 6, function-field width.
REQ-002 i_clock  in  1  sole clock; all state updates on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_start  in  1  EX-stage request valid for the current instruction.
REQ-005 i_function  in  NB_FUNCT  R-type funct: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
REQ-006 i_ra_data  in  NB_DATA  rs operand (dividend, multiplicand, MT source).
REQ-007 i_rb_data  in  NB_DATA  rt operand (divisor, multiplier).
REQ-008 o_stall  out  1  pipeline freeze request.
REQ-009 o_done  out  1  one-cycle pulse; HI/LO hold a new mult/div result.
REQ-010 o_div_by_zero  out  1  qualifies o_done; divisor was zero.
REQ-011 o_hi, o_lo  out  NB_DATA each  architectural HI/LO registers.
REQ-012 o_move_data  out  NB_DATA  combinational: o_hi when funct=MFHI, o_lo when funct=MFLO, else 0.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, FIX, DONE.
REQ-014 In IDLE, i_start with funct in {MULT, MULTU, DIV, DIVU} SHALL latch operands and signedness (cycle 0) and transition to RUN.
REQ-015 RUN SHALL perform exactly 32 iterations (5-bit counter 31 down to 0): shift-add multiply or restoring divide on operand magnitudes, then transition to FIX.
REQ-016 FIX SHALL apply sign correction (signed ops only: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write HI/LO on its closing edge, then transition to DONE.
REQ-017 DONE SHALL assert o_done for exactly one cycle (cycle 34) and return to IDLE.
REQ-018 o_stall SHALL be high combinationally in cycle 0 and in every RUN/FIX cycle (cycles 0-33), and low in IDLE without a mult/div start and in DONE.
REQ-019 MULT/MULTU: HI = product[63:32], LO = product[31:0].
REQ-020 DIV/DIVU: LO = quotient, HI = remainder; INT_MIN / -1 SHALL give LO=0x80000000, HI=0.
REQ-021 Divisor zero: LO=0xFFFFFFFF, HI=i_ra_data as latched, no sign correction; o_div_by_zero high with o_done only.
REQ-022 MTHI/MTLO with i_start in IDLE SHALL write i_ra_data to HI/LO on the next edge, no stall and no o_done.
REQ-023 i_start in any state other than IDLE SHALL be ignored; operands are not re-latched.
REQ-024 Unrecognised funct with i_start SHALL be ignored.

Reset
REQ-025 i_reset SHALL force IDLE, counter=0, HI=LO=0, o_done=0, o_div_by_zero=0, o_stall=0 on the next edge.
REQ-026 Reset mid-operation SHALL abandon the operation with no o_done and no HI/LO write other than clear.

Configuration
REQ-027 With MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL use a single-cycle native multiplier: IDLE->DONE directly, HI/LO written at the cycle-0 edge, o_stall high in cycle 0 only, o_done in cycle 1.
REQ-028 Without MULDIV_FAST_MUL_EN, multiply SHALL use the 34-cycle iterative path; divide is iterative in both builds.

Structure
REQ-029 Funct codes, FSM state encoding, and the iteration count (32) SHALL live in the shared mips package.
REQ-030 Shift/accumulate registers SHALL be one sub-module, muldiv_iter_unit; the FSM, HI/LO, and stall logic SHALL stay at the top level.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, o_stall cycles 0-33, o_done cycle 34 (cycle 1 with MULDIV_FAST_MUL_EN).
REQ-032 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-034 DIV 5/0 -> LO=0xFFFFFFFF, HI=5, o_div_by_zero=1 with o_done at cycle 34.
REQ-035 i_reset at cycle 10 of DIVU -> IDLE next cycle, HI=LO=0, no o_done; new MULTU 2x3 -> LO=6.
REQ-036 MTHI 0x1234 then MFHI -> o_move_data=0x1234; i_start MULT during an active DIV -> ignored, DIV result unchanged.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared mips definitions for the HI/LO multiply/divide sequencer:
// funct codes, FSM encoding and iteration count.
package muldiv_sequencer_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/muldiv_iter_unit.sv
// Shift/accumulate datapath: shift-add multiply or restoring divide
// on unsigned magnitudes, one bit per i_step.
module muldiv_iter_unit #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  logic [NB_DATA-1:0] hi_q;
  logic [NB_DATA-1:0] lo_q;
  logic [NB_DATA-1:0] b_q;
  logic               div_q;
  logic [NB_DATA:0]   sum;
  logic [NB_DATA:0]   shl;
  logic [NB_DATA:0]   diff;

  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, b_q};
    shl  = {hi_q, lo_q[NB_DATA-1]};
    diff = shl - {1'b0, b_q};
  end

  // lo holds multiplier or dividend; b holds multiplicand or divisor
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (i_load) begin
      hi_q  <= '0;
      lo_q  <= i_div ? i_a : i_b;
      b_q   <= i_div ? i_b : i_a;
      div_q <= i_div;
    end else if (i_step) begin
      if (div_q) begin
        if (!diff[NB_DATA]) begin
          hi_q <= diff[NB_DATA-1:0];
          lo_q <= {lo_q[NB_DATA-2:0], 1'b1};
        end else begin
          hi_q <= shl[NB_DATA-1:0];
          lo_q <= {lo_q[NB_DATA-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        {hi_q, lo_q} <= {sum, lo_q[NB_DATA-1:1]};
      end else begin
        {hi_q, lo_q} <= {1'b0, hi_q, lo_q[NB_DATA-1:1]};
      end
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO multiply/divide sequencer (IDLE/RUN/FIX/DONE).
// Define MULDIV_FAST_MUL_EN for a single-cycle native multiplier.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_FUNCT = 6
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_FUNCT-1:0] i_function,
  input  logic [NB_DATA-1:0]  i_ra_data,
  input  logic [NB_DATA-1:0]  i_rb_data,
  output logic                o_stall,
  output logic                o_done,
  output logic                o_div_by_zero,
  output logic [NB_DATA-1:0]  o_hi,
  output logic [NB_DATA-1:0]  o_lo,
  output logic [NB_DATA-1:0]  o_move_data
);

  localparam int MSB = NB_DATA - 1;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q;
  logic [NB_DATA-1:0] hi_q, lo_q, ra_q;
  logic               sgn_q, sb_q, div_q, dbz_q;
  logic               is_mul, is_div, is_sgn;
  logic               load, step;
  logic [NB_DATA-1:0] a_mag, b_mag;
  logic [NB_DATA-1:0] it_hi, it_lo;
  logic               neg_q, neg_r;
  logic [2*NB_DATA-1:0] prod, prod_fix;
  logic [NB_DATA-1:0] quo_fix, rem_fix;

  assign is_mul = (i_function == FN_MULT) || (i_function == FN_MULTU);
  assign is_div = (i_function == FN_DIV) || (i_function == FN_DIVU);
  assign is_sgn = (i_function == FN_MULT) || (i_function == FN_DIV);

  assign a_mag = (is_sgn && i_ra_data[MSB]) ? -i_ra_data : i_ra_data;
  assign b_mag = (is_sgn && i_rb_data[MSB]) ? -i_rb_data : i_rb_data;

  always_comb begin
    state_d = state_q;
    o_stall = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start && (is_mul || is_div)) begin
          o_stall = 1'b1;
          load    = 1'b1;
          state_d = ST_RUN;
`ifdef MULDIV_FAST_MUL_EN
          if (is_mul) state_d = ST_DONE;
`endif
        end
      end
      ST_RUN: begin
        o_stall = 1'b1;
        step    = 1'b1;
        if (cnt_q == 5'd0) state_d = ST_FIX;
      end
      ST_FIX: begin
        o_stall = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  muldiv_iter_unit #(.NB_DATA(NB_DATA)) u_iter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (load),
    .i_step  (step),
    .i_div   (is_div),
    .i_a     (a_mag),
    .i_b     (b_mag),
    .o_hi    (it_hi),
    .o_lo    (it_lo)
  );

  // Remainder follows the dividend sign; quotient/product the xor
  always_comb begin
    neg_q    = sgn_q && (ra_q[MSB] ^ sb_q);
    neg_r    = sgn_q && ra_q[MSB];
    prod     = {it_hi, it_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -it_lo : it_lo;
    rem_fix  = neg_r ? -it_hi : it_hi;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*NB_DATA-1:0] fa, fb, fprod;
  always_comb begin
    fa    = {{NB_DATA{is_sgn && i_ra_data[MSB]}}, i_ra_data};
    fb    = {{NB_DATA{is_sgn && i_rb_data[MSB]}}, i_rb_data};
    fprod = fa * fb;
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ra_q    <= '0;
      sgn_q   <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ra_q  <= i_ra_data;
        sgn_q <= is_sgn;
        sb_q  <= i_rb_data[MSB];
        div_q <= is_div;
        dbz_q <= is_div && (i_rb_data == '0);
        cnt_q <= 5'(ITER_COUNT - 1);
      end else if (step && cnt_q != 5'd0) begin
        cnt_q <= cnt_q - 5'd1;
      end
      if (state_q == ST_IDLE && i_start) begin
        if (i_function == FN_MTHI) hi_q <= i_ra_data;
        if (i_function == FN_MTLO) lo_q <= i_ra_data;
`ifdef MULDIV_FAST_MUL_EN
        if (is_mul) {hi_q, lo_q} <= fprod;
`endif
      end
      if (state_q == ST_FIX) begin
        if (!div_q) begin
          {hi_q, lo_q} <= prod_fix;
        end else if (dbz_q) begin
          hi_q <= ra_q;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end
    end
  end

  assign o_done        = (state_q == ST_DONE);
  assign o_div_by_zero = (state_q == ST_DONE) && dbz_q;
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;
  assign o_move_data   = (i_function == FN_MFHI) ? hi_q :
                         (i_function == FN_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall window,
// signed/unsigned results, divide-by-zero, reset abort, moves.
module tb_muldiv_sequencer;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] ra, rb;
  logic        stall, done, dbz;
  logic [31:0] hi, lo, mv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_function    (funct),
    .i_ra_data     (ra),
    .i_rb_data     (rb),
    .o_stall       (stall),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_hi          (hi),
    .o_lo          (lo),
    .o_move_data   (mv)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive cycle 0 of an op; returns in cycle 1
  task automatic start_op(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
    funct = f;
    ra    = a;
    rb    = b;
    start = 1'b1;
    #1 chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc,
                           input int cyc0, input logic exp_dbz);
    int cyc = cyc0;
    int stalls = 0;
    while (!done && cyc < 100) begin
      if (stall) stalls++;
      tick();
      cyc++;
    end
    chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_cyc - cyc0));
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
  endtask

  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic exp_dbz,
                        input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    start_op(tag, f, a, b);
    wait_done(tag, lat, 1, exp_dbz);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    funct = 6'h00;
    ra    = 32'd0;
    rb    = 32'd0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           MUL_LAT, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7,
           MUL_LAT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2,
           DIV_LAT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", DIVU, 32'd100, 32'd7,
           DIV_LAT, 1'b0, 32'd2, 32'd14);
    run_op("div_zero", DIV, 32'd5, 32'd0,
           DIV_LAT, 1'b1, 32'd5, 32'hFFFF_FFFF);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           DIV_LAT, 1'b0, 32'd0, 32'h8000_0000);

    // Abort a DIVU with reset in cycle 10
    run_op("pre_rst", MULTU, 32'd5, 32'd9,
           MUL_LAT, 1'b0, 32'd0, 32'd45);
    start_op("rst_mid", DIVU, 32'd1000, 32'd3);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    chk("rst_mid_no_done", 32'(seen), 32'd0);
    run_op("post_rst", MULTU, 32'd2, 32'd3,
           MUL_LAT, 1'b0, 32'd0, 32'd6);

    // Moves
    funct = MTHI;
    ra    = 32'h1234;
    start = 1'b1;
    #1 chk("mthi_stall", 32'(stall), 32'd0);
    tick();
    funct = MTLO;
    ra    = 32'hABCD;
    tick();
    start = 1'b0;
    chk("mt_done", 32'(done), 32'd0);
    funct = MFHI;
    #1 chk("mfhi", mv, 32'h1234);
    funct = MFLO;
    #1 chk("mflo", mv, 32'hABCD);
    funct = MULT;
    #1 chk("mv_other", mv, 32'd0);

    // Unknown funct is ignored
    funct = 6'h20;
    ra    = 32'h5555;
    start = 1'b1;
    #1 chk("bad_fn_stall", 32'(stall), 32'd0);
    tick();
    start = 1'b0;
    chk("bad_fn_hi", hi, 32'h1234);
    chk("bad_fn_lo", lo, 32'hABCD);
    tick();
    chk("bad_fn_done", 32'(done), 32'd0);

    // MULT request during an active DIVU is ignored
    start_op("busy", DIVU, 32'd100, 32'd7);
    funct = MULT;
    ra    = 32'd9;
    rb    = 32'd9;
    start = 1'b1;
    #1 chk("busy_stall", 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    wait_done("busy", DIV_LAT, 2, 1'b0);
    chk("busy_hi", hi, 32'd2);
    chk("busy_lo", lo, 32'd14);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
